// File: rtl/pc_fetch_if.sv
// rtl/pc_fetch_if.sv - program-load, run-control, decoder-feedback and fetch-output bundle for pc_fetch
interface pc_fetch_if #(
    parameter int ADDR_W = 4,
    parameter int OP_W   = 21,
    parameter int DATA_W = 11
);
    logic                     load_en;
    logic [ADDR_W-1:0]        load_addr;
    logic [OP_W-1:0]          load_data;
    logic                     run;
    logic                     stall;
    logic [3:0]               pc_instr;
    logic signed [DATA_W-1:0] const_val;
    logic signed [DATA_W-1:0] acc;
    logic signed [DATA_W-1:0] jro_val;
    logic [OP_W-1:0]          op_code;
    logic                     op_valid;
    logic [ADDR_W-1:0]        pc;
    logic [ADDR_W:0]          prog_len;

    modport master (
        output load_en, load_addr, load_data, run, stall, pc_instr, const_val, acc, jro_val,
        input  op_code, op_valid, pc, prog_len
    );

    modport slave (
        input  load_en, load_addr, load_data, run, stall, pc_instr, const_val, acc, jro_val,
        output op_code, op_valid, pc, prog_len
    );
endinterface

// File: rtl/pc_fetch.sv
// rtl/pc_fetch.sv - TIS-100 node program memory, PC sequencing and registered instruction fetch
module pc_fetch #(
    parameter int ADDR_W = 4,
    parameter int DEPTH  = 16,
    parameter int OP_W   = 21,
    parameter int DATA_W = 11
) (
    input  logic      clk,
    input  logic      rst_n,
    pc_fetch_if.slave bus
);
    localparam int LEN_W = ADDR_W + 1;

    typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;

    state_t             state, state_d;
    logic [ADDR_W-1:0]  pc, pc_d, pc_next;
    logic [OP_W-1:0]    op_code, op_d;
    logic               op_valid, valid_d;
    logic [LEN_W-1:0]   prog_len, len_d;
    logic [OP_W-1:0]    mem [DEPTH];

    logic [LEN_W-1:0]   last;
    logic [ADDR_W-1:0]  pc_seq, tgt_raw, jmp_tgt, jro_tgt;
    logic signed [DATA_W:0] jro_sum;
    logic               take;
    logic               unused_const_hi;

    assign unused_const_hi = ^bus.const_val[DATA_W-1:ADDR_W];

    always_ff @(posedge clk) begin
        if (bus.load_en) mem[bus.load_addr] <= bus.load_data;
    end

    // Targets are computed against the last valid address so every jump stays inside the program
    assign last    = prog_len - LEN_W'(1);
    assign pc_seq  = ({1'b0, pc} == last) ? '0 : pc + ADDR_W'(1);
    assign tgt_raw = bus.const_val[ADDR_W-1:0];
    assign jmp_tgt = ({1'b0, tgt_raw} >= prog_len) ? '0 : tgt_raw;
    assign jro_sum = $signed({{(DATA_W+1-ADDR_W){1'b0}}, pc})
                   + $signed({bus.jro_val[DATA_W-1], bus.jro_val});

    always_comb begin
        jro_tgt = jro_sum[ADDR_W-1:0];
        if (jro_sum[DATA_W])
            jro_tgt = '0;
        else if (jro_sum[DATA_W-1:0] > {{(DATA_W-LEN_W){1'b0}}, last})
            jro_tgt = last[ADDR_W-1:0];
    end

    always_comb begin
        take = 1'b0;
        case (bus.pc_instr)
            4'd1:    take = 1'b1;
            4'd2:    take = (bus.acc == '0);
            4'd3:    take = (bus.acc != '0);
            4'd4:    take = !bus.acc[DATA_W-1] && (bus.acc != '0);
            4'd5:    take = bus.acc[DATA_W-1];
            default: take = 1'b0;
        endcase
        if (bus.pc_instr == 4'd6)
            pc_next = jro_tgt;
        else if (take)
            pc_next = jmp_tgt;
        else
            pc_next = pc_seq;
    end

    always_comb begin
        state_d = state;
        pc_d    = pc;
        op_d    = op_code;
        valid_d = op_valid;
        len_d   = prog_len;
        if (bus.load_en) begin
            state_d = IDLE;
            pc_d    = '0;
            op_d    = '0;
            valid_d = 1'b0;
            len_d   = {1'b0, bus.load_addr} + LEN_W'(1);
        end else begin
            case (state)
                IDLE: begin
                    if (bus.run && (prog_len != '0)) state_d = PRIME;
                end
                PRIME: begin
                    op_d    = mem[0];
                    pc_d    = '0;
                    valid_d = 1'b1;
                    state_d = RUN;
                end
                RUN: begin
                    // run low wins over stall so a blocked node can still be halted
                    if (!bus.run) begin
                        state_d = IDLE;
                        pc_d    = '0;
                        op_d    = '0;
                        valid_d = 1'b0;
                    end else if (!bus.stall) begin
                        pc_d = pc_next;
                        op_d = mem[pc_next];
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            pc       <= '0;
            op_code  <= '0;
            op_valid <= 1'b0;
            prog_len <= '0;
        end else begin
            state    <= state_d;
            pc       <= pc_d;
            op_code  <= op_d;
            op_valid <= valid_d;
            prog_len <= len_d;
        end
    end

    assign bus.pc       = pc;
    assign bus.op_code  = op_code;
    assign bus.op_valid = op_valid;
    assign bus.prog_len = prog_len;
endmodule

// File: tb/tb_pc_fetch.sv
// tb/tb_pc_fetch.sv - directed self-checking bench for pc_fetch
module tb_pc_fetch;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   failures = 0;
    logic [20:0] exp_mem [16];

    pc_fetch_if #(.ADDR_W(4), .OP_W(21), .DATA_W(11)) bus ();

    pc_fetch #(.ADDR_W(4), .DEPTH(16), .OP_W(21), .DATA_W(11)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int a, input logic [20:0] d);
        bus.load_en   = 1'b1;
        bus.load_addr = 4'(a);
        bus.load_data = d;
        exp_mem[a]    = d;
        tick();
        bus.load_en   = 1'b0;
    endtask

    task automatic expect_live(input string tag, input int exp_pc);
        check({tag, ".valid"}, 32'(bus.op_valid), 32'd1);
        check({tag, ".pc"}, 32'(bus.pc), 32'(exp_pc));
        check({tag, ".op"}, 32'(bus.op_code), 32'(exp_mem[exp_pc]));
    endtask

    task automatic step(input string tag, input int instr, input int c, input int a,
                        input int j, input int exp_pc);
        bus.pc_instr  = 4'(instr);
        bus.const_val = 11'(c);
        bus.acc       = 11'(a);
        bus.jro_val   = 11'(j);
        tick();
        expect_live(tag, exp_pc);
        bus.pc_instr  = 4'd0;
        bus.acc       = '0;
        bus.jro_val   = '0;
        bus.const_val = '0;
    endtask

    initial begin
        rst_n = 1'b0;
        bus.load_en = 1'b0; bus.load_addr = '0; bus.load_data = '0;
        bus.run = 1'b0; bus.stall = 1'b0; bus.pc_instr = '0;
        bus.const_val = '0; bus.acc = '0; bus.jro_val = '0;
        tick(); tick();
        check("rst.valid", 32'(bus.op_valid), 32'd0);
        check("rst.pc", 32'(bus.pc), 32'd0);
        check("rst.op", 32'(bus.op_code), 32'd0);
        check("rst.len", 32'(bus.prog_len), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 3; i++) load(i, 21'(32'h1A5000 + i * 17));
        check("len3", 32'(bus.prog_len), 32'd3);
        check("len3.valid", 32'(bus.op_valid), 32'd0);
        bus.run = 1'b1;
        tick();
        check("prime.valid", 32'(bus.op_valid), 32'd0);
        tick();
        expect_live("first", 0);
        step("seq1", 0, 0, 0, 0, 1);
        step("seq2", 0, 0, 0, 0, 2);
        step("wrap", 0, 0, 0, 0, 0);
        step("seq1b", 0, 0, 0, 0, 1);
        bus.run = 1'b0;
        tick();
        check("halt.valid", 32'(bus.op_valid), 32'd0);
        check("halt.pc", 32'(bus.pc), 32'd0);
        check("halt.op", 32'(bus.op_code), 32'd0);

        for (int i = 0; i < 8; i++) load(i, 21'(32'h0C3000 + i * 257));
        check("len8", 32'(bus.prog_len), 32'd8);
        bus.run = 1'b1;
        tick(); tick();
        expect_live("p8.first", 0);
        step("p8.n1", 0, 0, 0, 0, 1);
        step("p8.n2", 0, 0, 0, 0, 2);
        step("p8.n3", 0, 0, 0, 0, 3);
        step("jmp6", 1, 6, 0, 0, 6);
        step("jmp12", 1, 12, 0, 0, 0);
        step("to2", 1, 2, 0, 0, 2);
        step("jez.taken", 2, 5, 0, 0, 5);
        step("back2a", 1, 2, 0, 0, 2);
        step("jez.not", 2, 5, -4, 0, 3);
        step("back2b", 1, 2, 0, 0, 2);
        step("jlz.taken", 5, 5, -4, 0, 5);
        step("back2c", 1, 2, 0, 0, 2);
        step("jgz.not", 4, 5, -4, 0, 3);
        step("jnz.not", 3, 5, 0, 0, 4);
        step("jgz.taken", 4, 1, 7, 0, 1);
        step("to5a", 1, 5, 0, 0, 5);
        step("jro.hi", 6, 0, 0, 10, 7);
        step("wrap8", 0, 0, 0, 0, 0);
        step("to5b", 1, 5, 0, 0, 5);
        step("jro.lo", 6, 0, 0, -1023, 0);
        step("to5c", 1, 5, 0, 0, 5);
        step("jro.zero", 6, 0, 0, 0, 5);
        step("jro.neg", 6, 0, 0, -2, 3);
        step("code9", 9, 1, 0, 0, 4);

        step("to1", 1, 1, 0, 0, 1);
        bus.stall = 1'b1;
        bus.pc_instr = 4'd1;
        bus.const_val = 11'd6;
        for (int i = 0; i < 3; i++) begin
            tick();
            expect_live("stall", 1);
        end
        bus.stall = 1'b0;
        step("unstall", 0, 0, 0, 0, 2);

        bus.stall = 1'b1;
        bus.run = 1'b0;
        tick();
        check("stallrun.valid", 32'(bus.op_valid), 32'd0);
        check("stallrun.pc", 32'(bus.pc), 32'd0);
        bus.stall = 1'b0;

        bus.run = 1'b1;
        tick(); tick();
        expect_live("rerun", 0);
        step("rerun.n1", 0, 0, 0, 0, 1);
        load(7, exp_mem[7]);
        check("load.valid", 32'(bus.op_valid), 32'd0);
        check("load.pc", 32'(bus.pc), 32'd0);
        check("load.op", 32'(bus.op_code), 32'd0);
        check("load.len", 32'(bus.prog_len), 32'd8);

        tick(); tick();
        expect_live("prereset", 0);
        rst_n = 1'b0;
        tick();
        check("midrst.valid", 32'(bus.op_valid), 32'd0);
        check("midrst.pc", 32'(bus.pc), 32'd0);
        check("midrst.len", 32'(bus.prog_len), 32'd0);
        check("midrst.op", 32'(bus.op_code), 32'd0);
        rst_n = 1'b1;
        tick(); tick(); tick();
        check("noprog.valid", 32'(bus.op_valid), 32'd0);

        bus.run = 1'b0;
        load(0, 21'h15A5A5);
        check("len1", 32'(bus.prog_len), 32'd1);
        bus.run = 1'b1;
        tick(); tick();
        expect_live("len1.first", 0);
        step("len1.next", 0, 0, 0, 0, 0);
        step("len1.jmp", 1, 3, 0, 0, 0);
        step("len1.jro", 6, 0, 0, 5, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
